// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and ID-stage FSM state type.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef enum logic {
      RUN,
      STALL
   } id_state_e;

endpackage

// File: rtl/id_stage_if.sv
// Bundle of fetch, register-file, writeback and execute-side signals around the decode stage.
interface id_stage_if
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_instr;
   logic [4:0]      addrA;
   logic [4:0]      addrB;
   logic [XLEN-1:0] dataA;
   logic [XLEN-1:0] dataB;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_rs1_val;
   logic [XLEN-1:0] out_rs2_val;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rd;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic            out_funct7b5;
   logic            out_is_load;

   modport slave (
      input  flush, in_valid, in_pc, in_instr, dataA, dataB,
             wb_we, wb_rd, wb_data, out_ready,
      output in_ready, addrA, addrB, out_valid, out_pc, out_rs1_val,
             out_rs2_val, out_imm, out_rd, out_opcode, out_funct3,
             out_funct7b5, out_is_load
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, dataA, dataB,
             wb_we, wb_rd, wb_data, out_ready,
      input  in_ready, addrA, addrB, out_valid, out_pc, out_rs1_val,
             out_rs2_val, out_imm, out_rd, out_opcode, out_funct3,
             out_funct7b5, out_is_load
   );

endinterface

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J layout from the opcode and sign-extends to XLEN.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (instr[6:0])
         OP_IMM, LOAD, JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
         STORE:              imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         BRANCH:             imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8], 1'b0};
         LUI, AUIPC:         imm32 = {instr[31:12], 12'b0};
         JAL:                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                      instr[20], instr[30:21], 1'b0};
         default:            imm32 = '0;
      endcase
   end

   // The 32-bit pattern is already sign-correct, so widening replicates bit 31.
   assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/id_stage.sv
// Decode stage feeding the ID/EX register, with load-use stall and flush.
// Define WB_BYPASS_EN to forward a same-cycle writeback onto the captured operands.
module id_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic        clk,
   input logic        rst_n,
   id_stage_if.slave  bus
);

   logic [6:0]      opcode;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            writes_rd;
   logic            advance;
   logic            hazard;
   logic            transfer;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm;

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rs1_val_q;
   logic [XLEN-1:0] rs2_val_q;
   logic [XLEN-1:0] imm_q;
   logic [4:0]      rd_q;
   logic [6:0]      opcode_q;
   logic [2:0]      funct3_q;
   logic            funct7b5_q;
   logic            is_load_q;

   id_state_e       state_q;
   id_state_e       state_d;

   assign opcode    = bus.in_instr[6:0];
   assign rs1       = bus.in_instr[19:15];
   assign rs2       = bus.in_instr[24:20];
   assign rd        = bus.in_instr[11:7];
   assign bus.addrA = rs1;
   assign bus.addrB = rs2;

   always_comb begin
      uses_rs1  = !(opcode inside {LUI, AUIPC, JAL});
      uses_rs2  = opcode inside {OP, STORE, BRANCH};
      writes_rd = !(opcode inside {STORE, BRANCH});
   end

   assign advance  = !valid_q | bus.out_ready;
   assign hazard   = valid_q & is_load_q & (rd_q != 5'd0) &
                     ((uses_rs1 & (rs1 == rd_q)) | (uses_rs2 & (rs2 == rd_q)));
   assign bus.in_ready = bus.flush | (advance & !hazard);
   assign transfer = bus.in_valid & bus.in_ready & !bus.flush;

`ifdef WB_BYPASS_EN
   // The register file cannot show a write to a same-cycle read, so forward it here.
   always_comb begin
      rs1_val = bus.dataA;
      rs2_val = bus.dataB;
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};

   always_comb begin
      rs1_val = bus.dataA;
      rs2_val = bus.dataB;
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end
`endif

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (bus.in_instr),
      .imm   (imm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (!bus.flush && hazard && advance && bus.in_valid) state_d = STALL;
         STALL:   state_d = RUN;
         default: state_d = RUN;
      endcase
      if (bus.flush) state_d = RUN;
   end

   // A stall needs no special case: hazard blocks transfer, so the advance branch drops out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= RESET_PC;
         rs1_val_q  <= '0;
         rs2_val_q  <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         opcode_q   <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         is_load_q  <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (transfer) begin
         valid_q    <= 1'b1;
         pc_q       <= bus.in_pc;
         rs1_val_q  <= rs1_val;
         rs2_val_q  <= rs2_val;
         imm_q      <= imm;
         rd_q       <= writes_rd ? rd : 5'd0;
         opcode_q   <= opcode;
         funct3_q   <= bus.in_instr[14:12];
         funct7b5_q <= bus.in_instr[30];
         is_load_q  <= (opcode == LOAD);
      end else if (advance) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_rs1_val  = rs1_val_q;
   assign bus.out_rs2_val  = rs2_val_q;
   assign bus.out_imm      = imm_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_opcode   = opcode_q;
   assign bus.out_funct3   = funct3_q;
   assign bus.out_funct7b5 = funct7b5_q;
   assign bus.out_is_load  = is_load_q;

endmodule
